// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b, cin, op
//   (00 ADD, 01 SUB, 10 ADDC, 11 SUBB); out_valid/out_ready, sum, cout,
//   ovf (signed overflow), zero (sum == 0). Latency STAGES cycles.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / BLOCK;
    localparam int L  = STAGES - 1;

    // One slice: returns {carry out, carry into MSB, sum}.
    function automatic logic [SW+1:0] cla(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          c0
    );
        logic [SW-1:0] p, g, s;
        logic [NG-1:0] gp, gg;
        logic [NG:0]   gc;
        logic [SW:0]   bc;
        logic          t, c;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[j*BLOCK +: BLOCK];
            gg[j] = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                t = g[j*BLOCK+i];
                for (int m = i + 1; m < BLOCK; m++)
                    t = t & p[j*BLOCK+m];
                gg[j] = gg[j] | t;
            end
        end
        // Group carries as flat sum-of-products over group P/G.
        gc[0] = c0;
        for (int j = 0; j < NG; j++) begin
            c = c0;
            for (int m = 0; m <= j; m++)
                c = c & gp[m];
            for (int i = 0; i <= j; i++) begin
                t = gg[i];
                for (int m = i + 1; m <= j; m++)
                    t = t & gp[m];
                c = c | t;
            end
            gc[j+1] = c;
        end
        // Bit carries inside a group, looked ahead from the group carry-in.
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                c = gc[j];
                for (int m = 0; m < i; m++)
                    c = c & p[j*BLOCK+m];
                for (int n = 0; n < i; n++) begin
                    t = g[j*BLOCK+n];
                    for (int m = n + 1; m < i; m++)
                        t = t & p[j*BLOCK+m];
                    c = c | t;
                end
                bc[j*BLOCK+i] = c;
            end
        end
        bc[SW] = gc[NG];
        s = p ^ bc[SW-1:0];
        return {bc[SW], bc[SW-1], s};
    endfunction

    logic             vq   [STAGES];
    logic [WIDTH-1:0] aq   [STAGES];
    logic [WIDTH-1:0] bq   [STAGES];
    logic             cq   [STAGES];
    logic             v_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] a_nx [STAGES];
    logic [SW+1:0]    res  [STAGES];
    logic [STAGES-1:0] ld;
    logic             ovf_q, zero_q;

    // aq holds finished low slices plus untouched high bits of a;
    // bq holds b, already inverted for SUB/SUBB.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                v_in[k] = in_valid;
                a_in[k] = a;
                b_in[k] = op[0] ? ~b : b;
                c_in[k] = op[1] ? cin : op[0];
            end else begin
                v_in[k] = vq[(k == 0) ? 0 : k-1];
                a_in[k] = aq[(k == 0) ? 0 : k-1];
                b_in[k] = bq[(k == 0) ? 0 : k-1];
                c_in[k] = cq[(k == 0) ? 0 : k-1];
            end
            res[k] = cla(a_in[k][k*SW +: SW], b_in[k][k*SW +: SW], c_in[k]);
            a_nx[k] = a_in[k];
            a_nx[k][k*SW +: SW] = res[k][SW-1:0];
        end
    end

    // Stage k can load if any stage at or after it is empty, or the
    // sink is taking the result; unrolled so there is no comb loop.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = out_ready;
            for (int m = k; m < STAGES; m++)
                ld[k] = ld[k] | !vq[m];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vq[k] <= 1'b0;
                aq[k] <= '0;
                bq[k] <= '0;
                cq[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vq[k] <= v_in[k];
                    if (v_in[k]) begin
                        aq[k] <= a_nx[k];
                        bq[k] <= b_in[k];
                        cq[k] <= res[k][SW+1];
                    end
                end
            end
            if (ld[L] && v_in[L]) begin
                ovf_q  <= res[L][SW] ^ res[L][SW+1];
                zero_q <= ~|a_nx[L];
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vq[L];
    assign sum       = aq[L];
    assign cout      = cq[L];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (32/4/2).
// Directed corner cases, backpressure, mid-flight reset, random scoreboard.
module tb_pipelined_cla_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    res_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   in_fire = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic [1:0] o);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         c0;
        res_t         r;
        yy = o[0] ? ~y : y;
        c0 = o[1] ? ci : o[0];
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
        r.s = full[W-1:0];
        r.c = full[W];
        r.v = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
        r.z = (r.s == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic new_op();
        a   = rnd_val();
        b   = rnd_val();
        cin = 1'($urandom % 2);
        op  = 2'($urandom % 4);
    endtask

    // Called at the negedge: record accepted ops, check delivered ones.
    task automatic score();
        res_t e;
        in_fire = in_valid && in_ready;
        if (in_fire)
            exp_q.push_back(model(a, b, cin, op));
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.v);
                chk("zero", zero, e.z);
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci,
                           input logic [1:0] o, input logic [W-1:0] es,
                           input logic ec, input logic ev, input logic ez);
        int lat;
        a = x; b = y; cin = ci; op = o;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, ev);
        chk({tag, "_zero"}, zero, ez);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] hold;
        bit           any;
        int           sent, cyc;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        run_one("add_wrap", 32'hFFFF_FFFF, 32'h1, 0, 2'b00, 32'h0, 1, 0, 1);
        run_one("add_ovf", 32'h7FFF_FFFF, 32'h1, 0, 2'b00, 32'h8000_0000, 0, 1, 0);
        run_one("sub_ovf", 32'h8000_0000, 32'h1, 0, 2'b01, 32'h7FFF_FFFF, 1, 1, 0);
        run_one("sub_neg", 32'h5, 32'h7, 0, 2'b01, 32'hFFFF_FFFE, 0, 0, 0);
        run_one("sub_pos", 32'h7, 32'h5, 0, 2'b01, 32'h2, 1, 0, 0);
        run_one("subb", 32'h7, 32'h5, 0, 2'b11, 32'h1, 1, 0, 0);
        run_one("addc", 32'h1, 32'h1, 1, 2'b10, 32'h3, 0, 0, 0);

        // Backpressure: sink stalled for 4 cycles with 4 ops queued.
        sent = 0; n_out = 0; in_fire = 0; in_valid = 0;
        for (int c = 0; c < 30; c++) begin
            if (!in_valid || in_fire) begin
                if (sent < 4) begin
                    new_op();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (c >= 4);
            @(negedge clk);
            if (c == 2) begin
                chk("bp_out_valid", out_valid, 1);
                hold = sum;
            end
            if (c == 2 || c == 3)
                chk("bp_in_ready_low", in_ready, 0);
            if (c == 3)
                chk("bp_stable", sum, hold);
            score();
            if (in_fire) sent++;
            @(posedge clk); #1;
        end
        chk("bp_delivered", n_out, 4);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset with two ops in flight.
        out_ready = 1'b0; in_fire = 0; in_valid = 0;
        for (int c = 0; c < 2; c++) begin
            new_op();
            in_valid = 1'b1;
            @(negedge clk);
            score();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_out_valid_pre", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_sum", sum, 0);
        chk("mid_flags", {cout, ovf, zero}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        any = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) any = 1;
        end
        chk("mid_no_stale", any, 0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        sent = 0; cyc = 0; n_out = 0; in_fire = 0; in_valid = 0;
        while ((sent < 3000 || exp_q.size() > 0) && cyc < 30000) begin
            if (!in_valid || in_fire) begin
                if (sent < 3000 && ($urandom % 10) < 7) begin
                    new_op();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (($urandom % 10) < 7);
            @(negedge clk);
            score();
            if (in_fire) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_delivered", n_out, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
